eco_vector_checker: RTL and testbench
=====================================

Name: eco_vector_checker

Overview:
- Self-contained exhaustive stimulus/response checker for small per-bit gate netlists under ECO.
- Acts as the other end of a DUT's a/b -> y interface: it drives every (a,b) combination into the DUT and reads back y.
- Compares each y against a built-in golden function and reports pass/fail, the mismatch count and the first failing vector.
- Sits in the gate_change test harness, wrapped around the netlist under test.

Parameters:
- WIDTH, 3, bit width of a, b and y.
- LAT, 0, DUT response latency in clocks (0 = combinational DUT).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- dut_a  output  WIDTH  stimulus a to DUT.
- dut_b  output  WIDTH  stimulus b to DUT.
- dut_y  input  WIDTH  DUT response.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at sweep end.
- pass  output  1  1 if the last completed sweep had zero mismatches; held until the next start.
- mismatch_count  output  2*WIDTH+1  number of failing vectors in the current/last sweep.
- first_fail_a  output  WIDTH  a of the first failing vector.
- first_fail_b  output  WIDTH  b of the first failing vector.
- first_fail_y  output  WIDTH  DUT y observed at the first failure.

Behaviour:
- Golden function:
  - y_exp[i] = ~(a[i] | b[i]) for i >= 1.
  - y_exp[0] = ~a[0] & b[0].
- Reset (async, any state):
  - state = IDLE, vector counter = 0, delay line cleared.
  - dut_a = dut_b = 0, busy = done = pass = 0.
  - mismatch_count = 0, first_fail_* = 0.
- State machine (registered, 4 states):
  - IDLE: start=1 -> DRIVE. On that edge: clear mismatch_count, first_fail_*, pass and the found-first flag; load counter = 0.
  - DRIVE: counter cnt of 2*WIDTH bits; dut_a = cnt[2W-1:W], dut_b = cnt[W-1:0] (registered outputs). cnt increments each cycle. After vector 2^(2W)-1 is presented: go to DRAIN if LAT > 0, else DONE.
  - DRAIN: stays exactly LAT cycles. dut_a/dut_b hold the last vector.
  - DONE: done=1 for one cycle; pass = (mismatch_count == 0), including a compare made in this same cycle; -> IDLE.
- Compare alignment:
  - A LAT-deep delay line carries (a, b, valid) alongside the stimulus.
  - The compare fires on each cycle whose delayed valid=1. Vector k is checked against dut_y sampled LAT cycles after it first appears on dut_a/dut_b.
  - LAT=0: compare in the same cycle the vector is presented.
  - Total compares per sweep = exactly 2^(2W).
- On mismatch (dut_y != y_exp):
  - mismatch_count += 1. Width 2W+1, so no overflow is possible.
  - If the first-fail flag is clear: capture first_fail_a/b/y and set the flag.
- busy = 1 in DRIVE, DRAIN and DONE; 0 in IDLE.
- Sweep length: start accepted at edge 0 -> done high in cycle 2^(2W)+LAT+1 (65 for defaults).
- Boundary conditions:
  - start while busy: ignored, no restart.
  - start asserted in the DONE cycle: ignored.
  - start held high: a new sweep starts on the next IDLE cycle.
  - Counter wrap from all-ones back to 0 is not used as the end condition; an explicit last-vector compare is.
  - rst mid-sweep: immediate return to reset values; partial results are discarded.
  - X on dut_y: counted as a mismatch (use a case-inequality compare in simulation only; synthesised logic uses plain !=).

Decomposition:
- Package eco_chk_pkg:
  - state enum {IDLE, DRIVE, DRAIN, DONE}.
  - default WIDTH constant.
  - function golden_y(a, b).
- Sub-module eco_golden_model:
  - purely combinational a,b -> y_exp, instantiated once.
  - lets the golden function be swapped per ECO case without touching the FSM.

Test Plan:
- Golden-correct DUT, LAT=0, pulse start -> done at cycle 65, pass=1, mismatch_count=0, busy low afterwards.
- DUT bit 0 = NOR(a0,b0) (pre-ECO function) -> mismatch_count=32.
  - first_fail_a=0, first_fail_b=0, first_fail_y=3'b111; pass=0.
- DUT y[2] stuck-at-0 -> mismatch_count=16.
  - first fail a=0, b=0, first_fail_y=3'b010.
- LAT=2 checker with a 2-stage registered golden DUT -> pass=1, done at cycle 67.
  - Same DUT with LAT=1 checker -> pass=0, mismatch_count>0.
- rst asserted at vector 20 -> all outputs zero immediately.
  - A new start then runs a full 64-vector sweep with correct results.
- start re-pulsed at cycles 10 and 65 (DONE) -> ignored.
  - Single sweep completes; start at cycle 66 begins a new sweep with cleared counters.

Source files
------------

// File: rtl/eco_chk_pkg.sv
// Shared types and the golden per-bit function for the ECO vector checker.
// Swap golden_y here when the target ECO function changes.
package eco_chk_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

  localparam int DEFAULT_WIDTH = 3;

  // Bit 0 is the post-ECO gate (~a & b); all other bits stay NOR.
  function automatic logic golden_y(input logic a, input logic b, input logic is_lsb);
    return is_lsb ? (~a & b) : ~(a | b);
  endfunction

endpackage

// File: rtl/eco_golden_model.sv
// Combinational reference: expected y for a given (a, b) pair.
module eco_golden_model
  import eco_chk_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y_exp
);

  always_comb begin
    y_exp = '0;
    for (int i = 0; i < WIDTH; i++) begin
      y_exp[i] = golden_y(a[i], b[i], (i == 0));
    end
  end

endmodule

// File: rtl/eco_vector_checker.sv
// Exhaustive (a,b) sweep driver and response checker for a small ECO netlist.
// Stimulus is registered; responses are compared LAT cycles after presentation.
module eco_vector_checker
  import eco_chk_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LAT   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   dut_a,
  output logic [WIDTH-1:0]   dut_b,
  input  logic [WIDTH-1:0]   dut_y,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   mismatch_count,
  output logic [WIDTH-1:0]   first_fail_a,
  output logic [WIDTH-1:0]   first_fail_b,
  output logic [WIDTH-1:0]   first_fail_y
);

  localparam int CW = 2 * WIDTH;
  localparam int DW = $clog2(LAT + 2);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic [CW:0]     mm_q, mm_d;
  logic [WIDTH-1:0] ffa_q, ffa_d, ffb_q, ffb_d, ffy_q, ffy_d;
  logic            found_q, found_d;
  logic            pass_q, pass_d;

  logic [WIDTH-1:0] cmp_a, cmp_b, y_exp;
  logic             cmp_vld, miss;

  // Delay line keeps each vector's (a, b, valid) aligned with the DUT's response.
  generate
    if (LAT == 0) begin : g_nodelay
      assign cmp_a   = cnt_q[CW-1:WIDTH];
      assign cmp_b   = cnt_q[WIDTH-1:0];
      assign cmp_vld = (state_q == DRIVE);
    end else begin : g_delay
      logic [WIDTH-1:0] dl_a_q [LAT];
      logic [WIDTH-1:0] dl_a_d [LAT];
      logic [WIDTH-1:0] dl_b_q [LAT];
      logic [WIDTH-1:0] dl_b_d [LAT];
      logic             dl_v_q [LAT];
      logic             dl_v_d [LAT];

      always_comb begin
        dl_a_d[0] = cnt_q[CW-1:WIDTH];
        dl_b_d[0] = cnt_q[WIDTH-1:0];
        dl_v_d[0] = (state_q == DRIVE);
        for (int i = 1; i < LAT; i++) begin
          dl_a_d[i] = dl_a_q[i-1];
          dl_b_d[i] = dl_b_q[i-1];
          dl_v_d[i] = dl_v_q[i-1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < LAT; i++) begin
            dl_a_q[i] <= '0;
            dl_b_q[i] <= '0;
            dl_v_q[i] <= 1'b0;
          end
        end else begin
          dl_a_q <= dl_a_d;
          dl_b_q <= dl_b_d;
          dl_v_q <= dl_v_d;
        end
      end

      assign cmp_a   = dl_a_q[LAT-1];
      assign cmp_b   = dl_b_q[LAT-1];
      assign cmp_vld = dl_v_q[LAT-1];
    end
  endgenerate

  eco_golden_model #(.WIDTH(WIDTH)) u_golden (
    .a     (cmp_a),
    .b     (cmp_b),
    .y_exp (y_exp)
  );

  // An X response from the netlist must count as a failure in simulation.
`ifdef SYNTHESIS
  assign miss = cmp_vld && (dut_y != y_exp);
`else
  assign miss = cmp_vld && (dut_y !== y_exp);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    mm_d    = mm_q;
    ffa_d   = ffa_q;
    ffb_d   = ffb_q;
    ffy_d   = ffy_q;
    found_d = found_q;
    pass_d  = pass_q;

    if (miss) begin
      mm_d = mm_q + (CW+1)'(1);
      if (!found_q) begin
        ffa_d   = cmp_a;
        ffb_d   = cmp_b;
        ffy_d   = dut_y;
        found_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          cnt_d   = '0;
          mm_d    = '0;
          ffa_d   = '0;
          ffb_d   = '0;
          ffy_d   = '0;
          found_d = 1'b0;
          pass_d  = 1'b0;
        end
      end
      DRIVE: begin
        // End on the explicit last vector, never on counter wrap.
        if (&cnt_q) begin
          if (LAT > 0) begin
            state_d = DRAIN;
            drain_d = DW'(LAT);
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (drain_q == DW'(1)) state_d = DONE;
        else                   drain_d = drain_q - DW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Verdict includes any compare landing on the edge that enters DONE.
    if (state_d == DONE && state_q != DONE) pass_d = (mm_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drain_q <= '0;
      mm_q    <= '0;
      ffa_q   <= '0;
      ffb_q   <= '0;
      ffy_q   <= '0;
      found_q <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      mm_q    <= mm_d;
      ffa_q   <= ffa_d;
      ffb_q   <= ffb_d;
      ffy_q   <= ffy_d;
      found_q <= found_d;
      pass_q  <= pass_d;
    end
  end

  assign dut_a          = cnt_q[CW-1:WIDTH];
  assign dut_b          = cnt_q[WIDTH-1:0];
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign pass           = pass_q;
  assign mismatch_count = mm_q;
  assign first_fail_a   = ffa_q;
  assign first_fail_b   = ffb_q;
  assign first_fail_y   = ffy_q;

endmodule

// File: tb/tb_eco_vector_checker.sv
// Scoreboarded bench: behavioural DUT variants, sweep-level reference model, done-driven monitor.
module tb_eco_vector_checker;

  localparam int W  = 3;
  localparam int NV = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start_l = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;
  int mode = 0;
  logic [W-1:0] fault_tab [NV];

  logic [W-1:0] a0, b0, y0, fa0, fb0, fy0;
  logic [W-1:0] a1, b1, y1, fa1, fb1, fy1;
  logic [W-1:0] a2, b2, y2, fa2, fb2, fy2;
  logic busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
  logic [2*W:0] mc0, mc1, mc2;

  eco_vector_checker #(.WIDTH(W), .LAT(0)) u_chk0 (
    .clk(clk), .rst(rst), .start(start), .dut_a(a0), .dut_b(b0), .dut_y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .mismatch_count(mc0),
    .first_fail_a(fa0), .first_fail_b(fb0), .first_fail_y(fy0));

  eco_vector_checker #(.WIDTH(W), .LAT(1)) u_chk1 (
    .clk(clk), .rst(rst), .start(start_l), .dut_a(a1), .dut_b(b1), .dut_y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .mismatch_count(mc1),
    .first_fail_a(fa1), .first_fail_b(fb1), .first_fail_y(fy1));

  eco_vector_checker #(.WIDTH(W), .LAT(2)) u_chk2 (
    .clk(clk), .rst(rst), .start(start_l), .dut_a(a2), .dut_b(b2), .dut_y(y2),
    .busy(busy2), .done(done2), .pass(pass2), .mismatch_count(mc2),
    .first_fail_a(fa2), .first_fail_b(fb2), .first_fail_y(fy2));

  function automatic logic [W-1:0] gold(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] y;
    for (int i = 0; i < W; i++) y[i] = (i == 0) ? (!a[i] && b[i]) : !(a[i] || b[i]);
    return y;
  endfunction

  // Netlist variants: 0 correct, 1 pre-ECO NOR on bit 0, 2 y[2] stuck-at-0, 3 random faults.
  function automatic logic [W-1:0] dut_fn(input int m, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] y;
    y = gold(a, b);
    case (m)
      1: y[0] = !(a[0] || b[0]);
      2: y[2] = 1'b0;
      3: y = y ^ fault_tab[{a, b}];
      default: ;
    endcase
    return y;
  endfunction

  always_comb y0 = dut_fn(mode, a0, b0);

  logic [W-1:0] p1a = '0, p1b = '0, p2a = '0, p2b = '0;
  always @(posedge clk) begin
    p1a <= gold(a1, b1);
    p1b <= p1a;
    p2a <= gold(a2, b2);
    p2b <= p2a;
  end
  assign y1 = p1b;
  assign y2 = p2b;

  typedef struct {
    int cnt;
    logic [W-1:0] fa, fb, fy;
    logic pass;
    int done_cyc;
  } exp_t;
  exp_t sb[$];

  function automatic exp_t model(input int m, input int start_cyc);
    exp_t e;
    e.cnt = 0; e.fa = '0; e.fb = '0; e.fy = '0;
    for (int k = 0; k < NV; k++) begin
      logic [W-1:0] a, b, y;
      a = W'(k >> W);
      b = W'(k);
      y = dut_fn(m, a, b);
      if (y != gold(a, b)) begin
        if (e.cnt == 0) begin e.fa = a; e.fb = b; e.fy = y; end
        e.cnt++;
      end
    end
    e.pass = (e.cnt == 0);
    e.done_cyc = start_cyc + NV + 1;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done0) begin
      chk("done_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("mismatch_count", int'(mc0), e.cnt);
        chk("pass", int'(pass0), int'(e.pass));
        chk("first_fail_a", int'(fa0), int'(e.fa));
        chk("first_fail_b", int'(fb0), int'(e.fb));
        chk("first_fail_y", int'(fy0), int'(e.fy));
        chk("done_cycle", cyc, e.done_cyc);
      end
    end
  end

  task automatic wait_sb(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("done_timeout_pending", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic sweep(input int m);
    mode = m;
    sb.push_back(model(m, cyc));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_sb(200);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dut_a"}, int'(a0), 0);
    chk({tag, "_dut_b"}, int'(b0), 0);
    chk({tag, "_busy"}, int'(busy0), 0);
    chk({tag, "_done"}, int'(done0), 0);
    chk({tag, "_pass"}, int'(pass0), 0);
    chk({tag, "_mismatch_count"}, int'(mc0), 0);
    chk({tag, "_ff_a"}, int'(fa0), 0);
    chk({tag, "_ff_b"}, int'(fb0), 0);
    chk({tag, "_ff_y"}, int'(fy0), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, d1c, d2c, m1, m2, p1, p2;
    for (int k = 0; k < NV; k++) fault_tab[k] = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    sweep(0);
    @(negedge clk);
    chk("busy_after_done", int'(busy0), 0);
    chk("done_one_cycle", int'(done0), 0);

    sweep(1);
    sweep(2);

    repeat (4) begin
      for (int k = 0; k < NV; k++)
        fault_tab[k] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(1, 7)) : '0;
      sweep(3);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    // Re-pulses while busy and in DONE are ignored; the pulse right after DONE restarts.
    mode = 1;
    s = cyc;
    sb.push_back(model(1, s));
    sb.push_back(model(1, s + NV + 2));
    for (int j = 0; j <= NV + 2; j++) begin
      start = (j == 0 || j == 10 || j == NV + 1 || j == NV + 2);
      @(negedge clk);
    end
    start = 1'b0;
    wait_sb(200);

    // start held high: back-to-back sweeps.
    mode = 2;
    s = cyc;
    sb.push_back(model(2, s));
    sb.push_back(model(2, s + NV + 2));
    start = 1'b1;
    repeat (NV + 3) @(negedge clk);
    start = 1'b0;
    wait_sb(200);

    // Reset in the middle of a failing sweep.
    mode = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && {a0, b0} != 6'd20; i++) @(negedge clk);
    chk("reached_vector_20", int'({a0, b0}), 20);
    chk("partial_mismatches_seen", int'(mc0 > 0), 1);
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sweep(2);

    // Latency alignment: 2-stage DUT against LAT=2 and LAT=1 checkers.
    d1c = -1; d2c = -1; m1 = -1; m2 = -1; p1 = -1; p2 = -1;
    s = cyc;
    start_l = 1'b1;
    @(negedge clk);
    start_l = 1'b0;
    for (int i = 0; i < 150 && (d1c < 0 || d2c < 0); i++) begin
      if (done1 && d1c < 0) begin d1c = cyc; m1 = int'(mc1); p1 = int'(pass1); end
      if (done2 && d2c < 0) begin d2c = cyc; m2 = int'(mc2); p2 = int'(pass2); end
      @(negedge clk);
    end
    chk("lat2_done_cycle", d2c, s + NV + 3);
    chk("lat2_pass", p2, 1);
    chk("lat2_mismatch_count", m2, 0);
    chk("lat1_done_cycle", d1c, s + NV + 2);
    chk("lat1_pass", p1, 0);
    chk("lat1_has_mismatch", int'(m1 > 0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
